mdu: RTL and testbench
======================

// Module: mdu
// PURPOSE
//  Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
//  Sits directly downstream of the register file read ports: operands arrive
//  from the rs/rt read data. Serves MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO.
//  Drives busy/stall_req to the hazard logic; its read result goes to the
//  register-file write-data mux.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   synchronous reset, active-high
//  start     in   1   launch operation op with operands a/b
//  op        in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a         in   32  rs operand (multiplicand / dividend)
//  b         in   32  rt operand (multiplier / divisor)
//  we_hi     in   1   MTHI: HI <= wdata
//  we_lo     in   1   MTLO: LO <= wdata
//  wdata     in   32  MTHI/MTLO data (rs read data)
//  rd_sel    in   1   0 -> rdata=LO (MFLO), 1 -> rdata=HI (MFHI)
//  rdata     out  32  combinational: selected HI/LO register value
//  hi, lo    out  32  architectural HI/LO registers
//  busy      out  1   registered; high while an operation is in flight
//  stall_req out  1   combinational: start | busy
//  done      out  1   registered; one-cycle pulse in the cycle HI/LO first show a result
// BEHAVIOUR
//  - Reset: HI=0, LO=0, busy=0, done=0, counter=0, operand/op latches=0.
//    Reset mid-operation aborts it; HI/LO are not updated from that operation.
//  - FSM: IDLE, RUN.
//    IDLE & start -> latch a, b, op; load counter with MULT_CYCLES or DIV_CYCLES
//    by op[1]; go to RUN.
//    In RUN, the counter decrements each cycle.
//    RUN & counter==1 -> write HI/LO; go to IDLE; done=1 next cycle.
//  - Timing: start sampled at edge E0 means busy=1 for exactly N cycles
//    (N = MULT_CYCLES or DIV_CYCLES). HI/LO carry the result, with busy=0 and
//    done=1, from edge E0+N onward.
//  - start while busy=1 is ignored; hazard logic guarantees it never happens.
//    The bench checks that it has no effect.
//  - we_hi/we_lo while busy=1 are ignored. When IDLE, they write at the next edge.
//    we_* and start in the same idle cycle: the MT write lands, and the operation
//    still launches. At completion, the result overwrites both HI and LO.
//  - Arithmetic: 64-bit products.
//    MULT uses signed a*b; MULTU uses unsigned a*b. HI=p[63:32], LO=p[31:0].
//  - Division: LO=quotient, HI=remainder.
//    DIV is signed, truncating toward zero; the remainder takes the sign of the
//    dividend. DIVU is unsigned.
//  - Boundary cases:
//    * Divide by zero (b==0): DIV/DIVU leave HI and LO unchanged. busy still lasts
//      DIV_CYCLES, and done still pulses.
//    * DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Wraps, no trap.
//  - Results are computed from the latched operands. Operand inputs may change
//    after the start cycle without effect.
//  - rdata reflects HI/LO combinationally. A value written at edge E is visible
//    after E; there is no internal bypass.
// TESTING
//  1 MULT a=7, b=0xFFFFFFFD: busy for 5 cycles -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulse.
//  2 MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE.
//    MULT with the same operands -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//  3 DIV a=0xFFFFFFF9 (-7), b=2: busy for 10 cycles -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    DIVU a=0xFFFFFFFF, b=0x10 -> LO=0x0FFFFFFF, HI=0xF.
//  4 MTHI 0x1234, MTLO 0x5678, then DIV with b=0 -> after 10 cycles,
//    HI=0x1234 and LO=0x5678 are unchanged; done pulses.
//  5 MULT in flight, then start DIV and we_hi at cycle 2 -> both ignored.
//    The MULT result lands at cycle 5. rd_sel=0/1 toggles rdata between LO and HI.
//  6 rst at cycle 3 of a DIV -> the next cycle shows busy=0, HI=LO=0, and no done pulse.

Source files
------------

// File: rtl/mdu_if.sv
// Handshake and data bundle between the pipeline and the multiply/divide unit.
// The master modport is the pipeline side; the slave modport is the unit itself.
interface mdu_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wdata;
  logic        rd_sel;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;
  logic        done;

  modport master (
    output start, op, a, b, we_hi, we_lo, wdata, rd_sel,
    input  rdata, hi, lo, busy, stall_req, done
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wdata, rd_sel,
    output rdata, hi, lo, busy, stall_req, done
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Operands are latched at launch; the result is committed after a fixed cycle count.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // 64-bit product; operands are widened first so the low 64 bits are exact.
  function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_signed);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
    eb = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Sign-magnitude division returning {remainder, quotient}. Working on magnitudes
  // makes 0x80000000 / -1 wrap to 0x80000000 instead of relying on signed overflow.
  function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_signed);
    logic        na;
    logic        nb;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    na = is_signed & a[31];
    nb = is_signed & b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    if (mb == 32'd0) mb = 32'd1;
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = -q;
    if (na)      r = -r;
    return {r, q};
  endfunction

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [1:0]       r_op;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_busy;
  logic             r_done;

  logic [63:0]      w_res;
  logic             w_wr_en;
  logic             w_last;

  assign w_res   = r_op[1] ? f_div(r_a, r_b, ~r_op[0]) : f_mul(r_a, r_b, ~r_op[0]);
  assign w_wr_en = !(r_op[1] && (r_b == 32'd0));
  assign w_last  = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        // MT writes and a launch may share an idle cycle; the result overwrites later.
        if (bus.we_hi) r_hi <= bus.wdata;
        if (bus.we_lo) r_lo <= bus.wdata;
        if (bus.start) begin
          r_a     <= bus.a;
          r_b     <= bus.b;
          r_op    <= bus.op;
          r_cnt   <= bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          r_state <= S_RUN;
          r_busy  <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) begin
          if (w_wr_en) begin
            r_hi <= w_res[63:32];
            r_lo <= w_res[31:0];
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.rdata     = bus.rd_sel ? r_hi : r_lo;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.stall_req = bus.start | r_busy;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random operations compared
// against an arithmetic reference model of the HI/LO registers.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic rst;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one completed operation, from plain 64-bit arithmetic.
  task automatic ref_apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic [63:0]     q;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b01: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b10: if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      default: if (b != 32'd0) begin q = ua / ub; r = ua % ub; m_lo = q[31:0]; m_hi = r[31:0]; end
    endcase
  endtask

  // Called just after a negedge. inject>0 drives a stray start DIV + MTHI in that busy cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject);
    int n;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    n = op[1] ? DC : MC;
    if (bus.we_hi) m_hi = bus.wdata;
    if (bus.we_lo) m_lo = bus.wdata;
    old_hi = m_hi;
    old_lo = m_lo;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    #1 chk("stall_on_start", {31'b0, bus.stall_req}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0; bus.we_hi = 1'b0; bus.we_lo = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    for (int k = 1; k <= n; k++) begin
      chk("busy_run", {31'b0, bus.busy}, 32'd1);
      chk("done_run", {31'b0, bus.done}, 32'd0);
      if (k == n) begin
        chk("hi_hold", bus.hi, old_hi);
        chk("lo_hold", bus.lo, old_lo);
      end
      if (k == inject) begin
        bus.start = 1'b1; bus.op = 2'b10; bus.b = 32'd3;
        bus.we_hi = 1'b1; bus.wdata = $urandom;
      end else begin
        bus.start = 1'b0; bus.we_hi = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.we_hi = 1'b0;
    ref_apply(op, a, b);
    chk("busy_end", {31'b0, bus.busy}, 32'd0);
    chk("done_pulse", {31'b0, bus.done}, 32'd1);
    chk("hi_res", bus.hi, m_hi);
    chk("lo_res", bus.lo, m_lo);
    @(negedge clk);
    chk("done_clear", {31'b0, bus.done}, 32'd0);
  endtask

  task automatic mt(input logic sel_hi, input logic [31:0] d);
    bus.we_hi = sel_hi; bus.we_lo = !sel_hi; bus.wdata = d;
    #1 chk("mt_no_bypass", sel_hi ? bus.hi : bus.lo, sel_hi ? m_hi : m_lo);
    @(negedge clk);
    bus.we_hi = 1'b0; bus.we_lo = 1'b0;
    if (sel_hi) m_hi = d; else m_lo = d;
    chk("mt_hi", bus.hi, m_hi);
    chk("mt_lo", bus.lo, m_lo);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.we_hi = 1'b0; bus.we_lo = 1'b0; bus.wdata = '0; bus.rd_sel = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_stall", {31'b0, bus.stall_req}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b00, 32'd7, 32'hFFFFFFFD, 0);
    chk("t1_hi", bus.hi, 32'hFFFFFFFF);
    chk("t1_lo", bus.lo, 32'hFFFFFFEB);

    run_op(2'b01, 32'hFFFFFFFF, 32'd2, 0);
    chk("t2u_hi", bus.hi, 32'h00000001);
    chk("t2u_lo", bus.lo, 32'hFFFFFFFE);
    run_op(2'b00, 32'hFFFFFFFF, 32'd2, 0);
    chk("t2s_hi", bus.hi, 32'hFFFFFFFF);
    chk("t2s_lo", bus.lo, 32'hFFFFFFFE);

    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
    chk("t3s_lo", bus.lo, 32'hFFFFFFFD);
    chk("t3s_hi", bus.hi, 32'hFFFFFFFF);
    run_op(2'b11, 32'hFFFFFFFF, 32'h10, 0);
    chk("t3u_lo", bus.lo, 32'h0FFFFFFF);
    chk("t3u_hi", bus.hi, 32'h0000000F);

    mt(1'b1, 32'h1234);
    mt(1'b0, 32'h5678);
    run_op(2'b10, 32'h11111111, 32'd0, 0);
    chk("t4_hi", bus.hi, 32'h1234);
    chk("t4_lo", bus.lo, 32'h5678);

    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("ovf_lo", bus.lo, 32'h80000000);
    chk("ovf_hi", bus.hi, 32'h0);

    // MTLO in the launch cycle lands, then the result overwrites it.
    bus.we_lo = 1'b1; bus.wdata = 32'hCAFEF00D;
    run_op(2'b01, 32'h00010000, 32'h00010000, 0);

    run_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 2);
    bus.rd_sel = 1'b0;
    #1 chk("rdata_lo", bus.rdata, m_lo);
    bus.rd_sel = 1'b1;
    #1 chk("rdata_hi", bus.rdata, m_hi);
    bus.rd_sel = 1'b0;

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (rb[31:30] == 2'b01) rb = {28'b0, rb[3:0]};
      if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1) == 1, $urandom);
      run_op(rop, ra, rb, 0);
    end

    // Reset during a divide aborts it without a result or done pulse.
    mt(1'b1, 32'hAAAA5555);
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_hi", bus.hi, m_hi);
    chk("abort_lo", bus.lo, m_lo);
    for (int k = 0; k < DC + 2; k++) begin
      @(negedge clk);
      chk("abort_nodone", {31'b0, bus.done}, 32'd0);
    end
    chk("abort_hi_late", bus.hi, 32'd0);
    chk("abort_lo_late", bus.lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
